// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types for the memory bus and its two-port arbiter.
package mem;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    WORD  = 2'd1,
    DWORD = 2'd2
  } mem_width_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } arb_port_t;

  function automatic arb_port_t other_port(arb_port_t p);
    return (p == PORT0) ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/memory_bus_arbiter_if.sv
// Request/response bus between a consumer and the memory system.
interface memory_bus;
  import mem::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  mem_width_t        mem_width;
  logic              dispatch_read;
  logic              dispatch_write;
  logic              busy;

  modport MEMORY_SYSTEM (
    input  addr, write_data, mem_width, dispatch_read, dispatch_write,
    output read_data, busy
  );

  modport CONSUMER (
    output addr, write_data, mem_width, dispatch_read, dispatch_write,
    input  read_data, busy
  );

endinterface

// File: rtl/memory_bus_arbiter_req_latch.sv
// Per-port request holder: captures a dispatch pulse, keeps it until the
// arbiter finishes it, and presents busy/read_data to the requester.
module mem_request_latch import mem::*; (
  input  logic              clk_in,
  input  logic              rst_in,
  memory_bus.MEMORY_SYSTEM  req,
  input  logic              clear_i,
  input  logic              load_rdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output mem_width_t        width_o,
  output logic              is_read_o,
  output logic              pending_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  mem_width_t        width_q;
  logic              is_read_q;
  logic              pending_q;
  logic              pending_d;
  logic              capture;

  // A dispatch arriving while a request is already held is dropped.
  assign capture = !pending_q && (req.dispatch_read || req.dispatch_write);

  always_comb begin
    pending_d = pending_q;
    if (capture) begin
      pending_d = 1'b1;
    end else if (clear_i) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      width_q   <= BYTE;
      is_read_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (capture) begin
        addr_q    <= req.addr;
        wdata_q   <= req.write_data;
        width_q   <= req.mem_width;
        is_read_q <= req.dispatch_read;
      end
      if (load_rdata_i) begin
        rdata_q <= rdata_i;
      end
    end
  end

  assign req.busy      = pending_q || req.dispatch_read || req.dispatch_write;
  assign req.read_data = rdata_q;

  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign width_o   = width_q;
  assign is_read_o = is_read_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/memory_bus_arbiter.sv
// Shares one downstream memory bus between two requesters: latches their
// dispatches, grants one at a time, and returns read data to the owner.
module memory_bus_arbiter import mem::*; #(
  parameter bit FIXED_PRIORITY = 1'b0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_in,
  input  logic             rst_in,
  memory_bus.MEMORY_SYSTEM req0,
  memory_bus.MEMORY_SYSTEM req1,
  memory_bus.CONSUMER      mem_out,
  output logic             owner,
  output logic             active,
  output logic             timeout_err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_t           state_q, state_d;
  arb_port_t        owner_q, owner_d;
  arb_port_t        last_grant_q, last_grant_d;
  arb_port_t        winner, sel;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             dispatch_rd, dispatch_wr;

  logic [ADDR_W-1:0] lat_addr  [2];
  logic [DATA_W-1:0] lat_wdata [2];
  mem_width_t        lat_width [2];
  logic [1:0]        lat_is_read;
  logic [1:0]        lat_pending;
  logic [1:0]        clear;
  logic [1:0]        load_rdata;

  mem_request_latch u_latch0 (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .req          (req0),
    .clear_i      (clear[0]),
    .load_rdata_i (load_rdata[0]),
    .rdata_i      (mem_out.read_data),
    .addr_o       (lat_addr[0]),
    .wdata_o      (lat_wdata[0]),
    .width_o      (lat_width[0]),
    .is_read_o    (lat_is_read[0]),
    .pending_o    (lat_pending[0])
  );

  mem_request_latch u_latch1 (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .req          (req1),
    .clear_i      (clear[1]),
    .load_rdata_i (load_rdata[1]),
    .rdata_i      (mem_out.read_data),
    .addr_o       (lat_addr[1]),
    .wdata_o      (lat_wdata[1]),
    .width_o      (lat_width[1]),
    .is_read_o    (lat_is_read[1]),
    .pending_o    (lat_pending[1])
  );

  // Ties go to port 0 under fixed priority, else to the port not last served.
  always_comb begin
    winner = PORT0;
    case (lat_pending)
      2'b01:   winner = PORT0;
      2'b10:   winner = PORT1;
      2'b11:   winner = FIXED_PRIORITY ? PORT0 : other_port(last_grant_q);
      default: winner = PORT0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    clear         = 2'b00;
    load_rdata    = 2'b00;
    dispatch_rd   = 1'b0;
    dispatch_wr   = 1'b0;
    sel           = winner;
    case (state_q)
      S_IDLE: begin
        if (|lat_pending) begin
          dispatch_rd  = lat_is_read[winner];
          dispatch_wr  = !lat_is_read[winner];
          owner_d      = winner;
          last_grant_d = winner;
          wait_cnt_d   = '0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        sel = owner_q;
        if (mem_out.busy) begin
          // Watchdog only flags a stuck bus; the transfer is never abandoned.
          if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
          if (wait_cnt_d == CNT_MAX) begin
            timeout_err_d = 1'b1;
          end
        end else begin
          clear[owner_q]      = 1'b1;
          load_rdata[owner_q] = lat_is_read[owner_q];
          state_d             = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      owner_q       <= PORT0;
      last_grant_q  <= PORT1;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_out.addr           = lat_addr[sel];
  assign mem_out.write_data     = lat_wdata[sel];
  assign mem_out.mem_width      = lat_width[sel];
  assign mem_out.dispatch_read  = dispatch_rd;
  assign mem_out.dispatch_write = dispatch_wr;

  assign owner       = owner_q;
  assign active      = (state_q == S_WAIT);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench: a round-robin arbiter (dut_a) and a fixed-priority one
// (dut_b) receive identical requester traffic, each with a stub memory.
module tb_memory_bus_arbiter;
  import mem::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        owner_a, active_a, tout_a;
  logic        owner_b, active_b, tout_b;
  int          checks = 0;
  int          errors = 0;
  int unsigned stub_lat;
  logic [31:0] stub_rdata;
  int unsigned cnt_a, cnt_b;

  memory_bus ra0 ();
  memory_bus ra1 ();
  memory_bus ma  ();
  memory_bus rb0 ();
  memory_bus rb1 ();
  memory_bus mb  ();

  always #5 clk_in = ~clk_in;

  memory_bus_arbiter #(.FIXED_PRIORITY(1'b0), .TIMEOUT_CYCLES(8)) dut_a (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .req0        (ra0),
    .req1        (ra1),
    .mem_out     (ma),
    .owner       (owner_a),
    .active      (active_a),
    .timeout_err (tout_a)
  );

  memory_bus_arbiter #(.FIXED_PRIORITY(1'b1), .TIMEOUT_CYCLES(8)) dut_b (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .req0        (rb0),
    .req1        (rb1),
    .mem_out     (mb),
    .owner       (owner_b),
    .active      (active_b),
    .timeout_err (tout_b)
  );

  // Stub memory: busy for stub_lat cycles after each dispatch.
  assign ma.busy      = (cnt_a != 0);
  assign ma.read_data = stub_rdata;
  assign mb.busy      = (cnt_b != 0);
  assign mb.read_data = stub_rdata;

  always @(posedge clk_in) begin
    if (rst_in) begin
      cnt_a <= 0;
      cnt_b <= 0;
    end else begin
      if (ma.dispatch_read || ma.dispatch_write) cnt_a <= stub_lat;
      else if (cnt_a != 0)                       cnt_a <= cnt_a - 1;
      if (mb.dispatch_read || mb.dispatch_write) cnt_b <= stub_lat;
      else if (cnt_b != 0)                       cnt_b <= cnt_b - 1;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input mem_width_t w);
    if (p == 0) begin
      ra0.dispatch_read = rd; ra0.dispatch_write = wr; ra0.addr = a; ra0.write_data = d; ra0.mem_width = w;
      rb0.dispatch_read = rd; rb0.dispatch_write = wr; rb0.addr = a; rb0.write_data = d; rb0.mem_width = w;
    end else begin
      ra1.dispatch_read = rd; ra1.dispatch_write = wr; ra1.addr = a; ra1.write_data = d; ra1.mem_width = w;
      rb1.dispatch_read = rd; rb1.dispatch_write = wr; rb1.addr = a; rb1.write_data = d; rb1.mem_width = w;
    end
  endtask

  task automatic idle_all();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, BYTE);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, BYTE);
  endtask

  initial begin
    rst_in     = 1'b1;
    stub_lat   = 4;
    stub_rdata = 32'h0;
    idle_all();
    tick();
    tick();
    $display("reset state");
    chk("rst_active", active_a, 1'b0);
    chk("rst_owner", owner_a, 1'b0);
    chk("rst_timeout", tout_a, 1'b0);
    chk("rst_busy0", ra0.busy, 1'b0);
    chk("rst_rdata0", ra0.read_data, 32'h0);
    chk("rst_disp_rd", ma.dispatch_read, 1'b0);
    rst_in = 1'b0;

    // Single read on port 0, 4 busy cycles downstream
    stub_rdata = 32'hCAFE_F00D;
    drive(0, 1'b1, 1'b0, 32'h1000_0004, 32'h0, DWORD);
    #1;
    $display("single read: port0 dispatch 0x10000004");
    chk("t1_busy0_comb", ra0.busy, 1'b1);
    chk("t1_busy1_idle", ra1.busy, 1'b0);
    tick(); idle_all(); #1;
    chk("t1_ds_rd", ma.dispatch_read, 1'b1);
    chk("t1_ds_wr", ma.dispatch_write, 1'b0);
    chk("t1_ds_addr", ma.addr, 32'h1000_0004);
    chk("t1_ds_width", ma.mem_width, DWORD);
    chk("t1_active_issue", active_a, 1'b0);
    tick(); #1;
    chk("t1_active_wait", active_a, 1'b1);
    chk("t1_owner", owner_a, 1'b0);
    chk("t1_ds_rd_pulse", ma.dispatch_read, 1'b0);
    chk("t1_addr_hold", ma.addr, 32'h1000_0004);
    repeat (4) tick();
    chk("t1_busy0_compl", ra0.busy, 1'b1);
    tick();
    $display("single read: returned %h", ra0.read_data);
    chk("t1_rdata0", ra0.read_data, 32'hCAFE_F00D);
    chk("t1_busy0_done", ra0.busy, 1'b0);
    chk("t1_active_done", active_a, 1'b0);
    chk("t1_rdata1", ra1.read_data, 32'h0);

    // Simultaneous tie right after reset
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    stub_lat   = 2;
    stub_rdata = 32'h1111_1111;
    drive(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, DWORD);
    drive(1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, DWORD);
    tick(); idle_all(); #1;
    $display("tie after reset: first grant addr A=%h B=%h", ma.addr, mb.addr);
    chk("t2_a_first", ma.addr, 32'h0000_0100);
    chk("t2_b_first", mb.addr, 32'h0000_0100);
    chk("t2_a_rd", ma.dispatch_read, 1'b1);
    repeat (4) tick(); #1;
    chk("t2_a_second_rd", ma.dispatch_read, 1'b1);
    chk("t2_a_second", ma.addr, 32'h0000_0200);
    chk("t2_b_second", mb.addr, 32'h0000_0200);
    chk("t2_rdata0", ra0.read_data, 32'h1111_1111);
    chk("t2_busy0", ra0.busy, 1'b0);
    chk("t2_busy1", ra1.busy, 1'b1);
    stub_rdata = 32'h2222_2222;
    tick();
    chk("t2_owner1", owner_a, 1'b1);
    repeat (3) tick();
    chk("t2_rdata1", ra1.read_data, 32'h2222_2222);
    chk("t2_idle", active_a, 1'b0);

    // Port 0 alone, then a tie: round-robin favours port 1, fixed favours port 0
    stub_rdata = 32'h3333_3333;
    drive(0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, DWORD);
    tick(); idle_all();
    repeat (4) tick();
    chk("t2_solo_rdata", ra0.read_data, 32'h3333_3333);
    stub_rdata = 32'h4444_4444;
    drive(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, DWORD);
    drive(1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, DWORD);
    tick(); idle_all(); #1;
    $display("repeat tie: first grant addr A=%h B=%h", ma.addr, mb.addr);
    chk("t2_rr_first", ma.addr, 32'h0000_0500);
    chk("t3_fp_first", mb.addr, 32'h0000_0400);
    tick();
    chk("t2_rr_owner", owner_a, 1'b1);
    chk("t3_fp_owner", owner_b, 1'b0);
    repeat (3) tick(); #1;
    chk("t2_rr_second", ma.addr, 32'h0000_0400);
    chk("t2_rr_second_rd", ma.dispatch_read, 1'b1);
    chk("t3_fp_second", mb.addr, 32'h0000_0500);
    chk("t3_fp_second_rd", mb.dispatch_read, 1'b1);
    repeat (4) tick();
    chk("t2_a_idle", active_a, 1'b0);
    chk("t3_b_idle", active_b, 1'b0);
    chk("t2_a_rdata1", ra1.read_data, 32'h4444_4444);
    chk("t3_b_rdata0", rb0.read_data, 32'h4444_4444);

    // Write on port 1
    stub_rdata = 32'hDEAD_BEEF;
    drive(1, 1'b0, 1'b1, 32'h2000_0010, 32'h0000_F800, WORD);
    #1;
    chk("t4_busy1_comb", ra1.busy, 1'b1);
    tick(); idle_all(); #1;
    $display("write: ds addr %h data %h wr %0b", ma.addr, ma.write_data, ma.dispatch_write);
    chk("t4_ds_wr", ma.dispatch_write, 1'b1);
    chk("t4_ds_rd", ma.dispatch_read, 1'b0);
    chk("t4_ds_addr", ma.addr, 32'h2000_0010);
    chk("t4_ds_data", ma.write_data, 32'h0000_F800);
    chk("t4_ds_width", ma.mem_width, WORD);
    tick(); #1;
    chk("t4_wr_pulse", ma.dispatch_write, 1'b0);
    chk("t4_data_hold", ma.write_data, 32'h0000_F800);
    chk("t4_active", active_a, 1'b1);
    repeat (3) tick();
    chk("t4_rdata1_kept", ra1.read_data, 32'h4444_4444);
    chk("t4_busy1_done", ra1.busy, 1'b0);

    // Reset while waiting with both ports pending
    stub_lat = 4;
    drive(0, 1'b1, 1'b0, 32'h0000_0600, 32'h0, DWORD);
    drive(1, 1'b1, 1'b0, 32'h0000_0700, 32'h0, DWORD);
    tick(); idle_all();
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    #1;
    $display("reset mid-transaction");
    chk("t5_busy0", ra0.busy, 1'b0);
    chk("t5_busy1", ra1.busy, 1'b0);
    chk("t5_rdata0", ra0.read_data, 32'h0);
    chk("t5_rdata1", ra1.read_data, 32'h0);
    chk("t5_active", active_a, 1'b0);
    chk("t5_owner", owner_a, 1'b0);
    chk("t5_disp_rd", ma.dispatch_read, 1'b0);
    chk("t5_disp_wr", ma.dispatch_write, 1'b0);
    tick(); #1;
    chk("t5_no_residue", ma.dispatch_read, 1'b0);
    drive(0, 1'b1, 1'b0, 32'h0000_0800, 32'h0, DWORD);
    drive(1, 1'b1, 1'b0, 32'h0000_0900, 32'h0, DWORD);
    tick(); idle_all(); #1;
    chk("t5_tie_first", ma.addr, 32'h0000_0800);
    chk("t5_tie_first_rd", ma.dispatch_read, 1'b1);
    repeat (12) tick();
    chk("t5_drained", active_a, 1'b0);
    chk("t5_busy1_done", ra1.busy, 1'b0);

    // Watchdog: 20 busy cycles against an 8-cycle limit
    stub_lat   = 20;
    stub_rdata = 32'h5555_AAAA;
    drive(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, DWORD);
    tick(); idle_all();
    repeat (8) tick();
    chk("t6_no_timeout_yet", tout_a, 1'b0);
    tick();
    $display("timeout: err A=%0b B=%0b", tout_a, tout_b);
    chk("t6_timeout_set", tout_a, 1'b1);
    chk("t6_timeout_set_b", tout_b, 1'b1);
    repeat (11) tick();
    chk("t6_still_active", active_a, 1'b1);
    chk("t6_sticky", tout_a, 1'b1);
    tick();
    tick();
    chk("t6_rdata", ra0.read_data, 32'h5555_AAAA);
    chk("t6_busy_done", ra0.busy, 1'b0);
    chk("t6_sticky_after", tout_a, 1'b1);
    chk("t6_idle", active_a, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Two-port arbiter that shares the single `memory_system` bus between two consumers: port 0 (CPU load/store unit) and port 1 (DMA/blitter). Each requester sees a `memory_bus` with unchanged semantics. The arbiter latches one-cycle dispatch pulses, picks a winner, replays the request downstream, waits for completion, then returns read data to the owner. It sits between the requesters and `memory_system.bus`.

## Interface
Parameters:
- `FIXED_PRIORITY`, default 0: 0 = round-robin; 1 = port 0 always wins ties.
- `TIMEOUT_CYCLES`, default 1024: downstream busy cycles before `timeout_err` sets.

Ports:
- `clk_in`  input  1: single clock.
- `rst_in`  input  1: synchronous, active-high reset.
- `req0`  `memory_bus.MEMORY_SYSTEM`  —: port 0 requester side.
- `req1`  `memory_bus.MEMORY_SYSTEM`  —: port 1 requester side.
- `mem_out`  `memory_bus.CONSUMER`  —: to `memory_system.bus`.
- `owner`  output  1: port currently granted; valid while `active`.
- `active`  output  1: a downstream transaction is in flight.
- `timeout_err`  output  1: sticky; cleared only by reset.

## Operation
- **Capture, per port.** `dispatch_read` or `dispatch_write` high while `pending[i]==0` latches `addr`, `write_data`, `mem_width`, and `is_read`, then sets `pending[i]`.
  - `is_read = dispatch_read`: read wins if both dispatch lines are high, matching `memory_system`.
  - A dispatch while `pending[i]` is set is ignored.
- **Requester busy.** `req_i.busy = pending[i] || req_i.dispatch_read || req_i.dispatch_write`. This is combinational, so busy is high in the dispatch cycle.
- **Requester read data.** `req_i.read_data` is a register. It updates only on completion of a read owned by port i and holds otherwise.
- **FSM states:** IDLE and WAIT.
  - IDLE, no pending: `mem_out.dispatch_*`=0; stay in IDLE.
  - IDLE, any pending: select a winner (see arbitration) and drive `mem_out.addr`, `write_data`, `mem_width` from the winner's latch.
  - In the same cycle, assert `mem_out.dispatch_read` or `dispatch_write` (exactly one, for exactly one cycle). Record `owner`, update `last_grant`, go to WAIT.
  - WAIT: hold `mem_out` address/data/width stable; dispatch lines are 0.
  - WAIT, `mem_out.busy==0`: if `is_read`, copy `mem_out.read_data` into `req_owner.read_data`. Clear `pending[owner]` and return to IDLE.
- **Arbitration.**
  - Only one pending: it wins.
  - Both pending, `FIXED_PRIORITY=1`: port 0 wins.
  - Both pending, otherwise: the port ≠ `last_grant` wins.
  - `last_grant` resets to 1, so port 0 wins the first tie.
- **Watchdog.** `wait_cnt` clears on entry to WAIT and increments each WAIT cycle with busy high. It saturates at `TIMEOUT_CYCLES`, where `timeout_err` sets. The transaction is never aborted; the arbiter keeps waiting.
- **Outputs.** `active` = (state==WAIT). `mem_out.addr`, `write_data`, `mem_width` are don't-care in IDLE with no pending request; drive them from port 0's latch.

## Timing
- Request dispatched in cycle N → `pending` set at edge N+1 → downstream dispatch in cycle N+1 if the arbiter is IDLE.
- Downstream busy low in WAIT cycle M → read data visible on `req_i.read_data` and `req_i.busy` low in cycle M+1.
- Added latency is 1 cycle on issue and 1 on return, versus direct connection.
- Back-to-back: completion in cycle M → IDLE in M+1 → the other pending port dispatches in M+1.
- **Simultaneous events:**
  - Both ports dispatch in the same cycle: both latch; arbitration picks the winner, and the loser issues right after the winner completes.
  - Requester j dispatches during port i's completion cycle: j is latched normally.
- **Reset (any cycle, including mid-transaction):** state=IDLE, `pending`=0, `req_i.read_data`=0, `last_grant`=1, `wait_cnt`=0, `timeout_err`=0, `mem_out.dispatch_*`=0, `owner`=0, `active`=0. `memory_system` shares `rst_in`, so no downstream residue survives reset.

## Structure
- Add `arb_port_t` {PORT0=0, PORT1=1} to package `mem`. The existing `mem_width_t` is reused.
- The FSM state enum stays local to the module.
- Sub-module `mem_request_latch`, instantiated once per port:
  - holds addr/data/width/`is_read`/`pending`;
  - `clear` input from the arbiter;
  - drives requester `busy` and `read_data`.
- Arbitration, FSM and watchdog stay in `memory_bus_arbiter`.

## Test plan
- **Single read:** port 0 reads addr 0x1000_0004 DWORD; stub downstream busy for 4 cycles returning 0xCAFE_F00D → `req0.read_data`=0xCAFE_F00D one cycle after downstream busy drops; `req1.read_data` stays 0.
- **Simultaneous tie:** both ports dispatch in the same cycle with `FIXED_PRIORITY=0` after reset → port 0 is served first, then port 1 immediately. A repeat tie serves port 1 first.
- **Fixed priority:** `FIXED_PRIORITY=1`, both ports re-dispatch continuously → port 0 always wins ties; port 1 is served only when port 0 is not pending.
- **Write:** port 1 writes 0x2000_0010 ← 0x0000_F800 WORD → downstream sees one-cycle `dispatch_write` with matching addr/data/width; `req1.read_data` unchanged.
- **Reset mid-transaction:** assert `rst_in` during WAIT with both ports pending → next cycle all `busy`=0, `read_data`=0, no downstream dispatch; a port 0 read issued afterwards wins the first tie.
- **Timeout:** `TIMEOUT_CYCLES`=8, downstream busy held for 20 cycles → `timeout_err` rises after 8 WAIT cycles and stays high; the transaction completes normally when busy drops.
